// File: rtl/io_frame_reader_pkg.sv
// io_frame_reader_pkg: constants shared between the IO address decoder and
// the frame reader, plus the frame reader's state and source types.
package io_frame_reader_pkg;

    localparam int ADDR_W     = 22;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = 307200;
    localparam int ORIG_BASE  = 120;
    localparam int PROC_BASE  = 307320;

    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_RUN   = 2'd1,
        FR_DRAIN = 2'd2
    } frame_state_t;

    typedef enum logic {
        SRC_ORIG = 1'b0,
        SRC_PROC = 1'b1
    } frame_src_t;

    // First RAM address of the selected image region
    function automatic logic [ADDR_W-1:0] frame_base(input frame_src_t src);
        logic [ADDR_W-1:0] base;
        case (src)
            SRC_ORIG: base = ADDR_W'(ORIG_BASE);
            SRC_PROC: base = ADDR_W'(PROC_BASE);
            default:  base = ADDR_W'(ORIG_BASE);
        endcase
        return base;
    endfunction

endpackage

// File: rtl/io_frame_reader_if.sv
// io_frame_reader_if: pixel stream from the frame reader to the display path.
// The master drives pixels and frame markers, the slave answers with ready.
interface io_frame_reader_if #(
    parameter int PIX_W = 8
) ();
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic             pix_eof;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        output pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        input  pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/io_frame_reader_skid.sv
// pixel_skid_buffer: 2-entry valid/ready buffer. slot0 is always the head and
// drives the output directly, so the presented word only changes on a pop.
module pixel_skid_buffer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   level
);
    logic [W-1:0] slot0_r;
    logic [W-1:0] slot1_r;
    logic [1:0]   level_r;
    logic         pop_s;

    assign pop_s     = out_valid & out_ready;
    assign out_valid = (level_r != 2'd0);
    assign out_data  = slot0_r;
    assign level     = level_r;

    // Push/pop bookkeeping; a push into a full buffer is dropped (the reader never issues one)
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot0_r <= '0;
            slot1_r <= '0;
            level_r <= 2'd0;
        end else begin
            case ({in_valid, pop_s})
                2'b10: begin
                    case (level_r)
                        2'd0: begin
                            slot0_r <= in_data;
                            level_r <= 2'd1;
                        end
                        2'd1: begin
                            slot1_r <= in_data;
                            level_r <= 2'd2;
                        end
                        default: level_r <= level_r;
                    endcase
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    level_r <= level_r - 2'd1;
                end
                2'b11: begin
                    if (level_r == 2'd1) begin
                        slot0_r <= in_data;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= in_data;
                    end
                end
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: rtl/io_frame_reader.sv
// io_frame_reader: on a start pulse, reads one image region (original or
// processed) from the image RAM and streams it out as a valid/ready pixel
// stream with start/end-of-frame markers.
// Build option: define IO_FRAME_LOOP_EN for continuous refresh of the
// selected source; the default build is single-shot.
module io_frame_reader
    import io_frame_reader_pkg::*;
#(
    parameter int FRAME_PIXELS = IMG_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_orig,
    input  logic              start_proc,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  rd_data,
    io_frame_reader_if.master stream,
    output logic              busy
);
    localparam int CNT_W = $clog2(FRAME_PIXELS);
    localparam int BUF_W = PIX_W + 2;

    frame_state_t      state_r;
    frame_src_t        src_r;
`ifdef IO_FRAME_LOOP_EN
    frame_src_t        next_src_r;
`endif
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              pend_r;
    logic              pend_sof_r;
    logic              pend_eof_r;

    logic [1:0]        level_s;
    logic [BUF_W-1:0]  buf_out_s;
    logic              issue_s;
    logic              pop_s;
    logic              start_s;
    logic              last_s;
    logic              eof_hs_s;
    frame_src_t        start_src_s;

    assign start_s  = start_orig | start_proc;
    assign pop_s    = stream.pix_valid & stream.pix_ready;
    assign eof_hs_s = pop_s & stream.pix_eof;
    assign last_s   = (cnt_r == CNT_W'(FRAME_PIXELS - 1));
    assign busy     = (state_r != FR_IDLE);
    assign rd_addr  = addr_r;
    assign rd_en    = issue_s;

    // Original wins when both start pulses arrive together
    always_comb begin
        start_src_s = SRC_PROC;
        if (start_orig) begin
            start_src_s = SRC_ORIG;
        end else begin
            start_src_s = SRC_PROC;
        end
    end

    // Issue a read when the buffer can still hold it in the worst case; this
    // cycle's pop is credited so a ready consumer sees one pixel every cycle
    always_comb begin
        issue_s = 1'b0;
        if (state_r == FR_RUN) begin
            issue_s = (({1'b0, level_s} + {2'b00, pend_r}) < (3'd2 + {2'b00, pop_s}));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Frame FSM, source latch, pixel counter and in-flight read tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= FR_IDLE;
            src_r      <= SRC_ORIG;
`ifdef IO_FRAME_LOOP_EN
            next_src_r <= SRC_ORIG;
`endif
            cnt_r      <= '0;
            addr_r     <= '0;
            pend_r     <= 1'b0;
            pend_sof_r <= 1'b0;
            pend_eof_r <= 1'b0;
        end else begin
            pend_r     <= issue_s;
            pend_sof_r <= issue_s & (cnt_r == '0);
            pend_eof_r <= issue_s & last_s;
            case (state_r)
                FR_IDLE: begin
                    if (start_s) begin
                        state_r    <= FR_RUN;
                        src_r      <= start_src_s;
`ifdef IO_FRAME_LOOP_EN
                        next_src_r <= start_src_s;
`endif
                        cnt_r      <= '0;
                        addr_r     <= frame_base(start_src_s);
                    end else begin
                        state_r <= FR_IDLE;
                    end
                end
                FR_RUN: begin
                    if (issue_s) begin
                        addr_r <= addr_r + ADDR_W'(1);
                        if (last_s) begin
                            state_r <= FR_DRAIN;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= FR_RUN;
                    end
                end
                FR_DRAIN: begin
                    if (eof_hs_s) begin
`ifdef IO_FRAME_LOOP_EN
                        state_r <= FR_RUN;
                        src_r   <= next_src_r;
                        cnt_r   <= '0;
                        addr_r  <= frame_base(next_src_r);
`else
                        state_r <= FR_IDLE;
`endif
                    end else begin
                        state_r <= FR_DRAIN;
                    end
                end
                default: state_r <= FR_IDLE;
            endcase
`ifdef IO_FRAME_LOOP_EN
            // While looping, a start of the other source takes effect at the next frame
            if ((state_r != FR_IDLE) && start_s && (start_src_s != src_r)) begin
                next_src_r <= start_src_s;
            end
`endif
        end
    end

    pixel_skid_buffer #(.W(BUF_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pend_r),
        .in_data   ({pend_sof_r, pend_eof_r, rd_data}),
        .out_valid (stream.pix_valid),
        .out_ready (stream.pix_ready),
        .out_data  (buf_out_s),
        .level     (level_s)
    );

    assign stream.pix_sof  = buf_out_s[BUF_W-1];
    assign stream.pix_eof  = buf_out_s[BUF_W-2];
    assign stream.pix_data = buf_out_s[PIX_W-1:0];

endmodule

// File: tb/tb_io_frame_reader.sv
// tb_io_frame_reader: randomized bench for io_frame_reader with a 16-pixel
// frame. A queue-based model of the expected pixel stream and read addresses
// is checked every cycle; directed steps pin the model with literal values.
module tb_io_frame_reader;
    localparam int NPIX = 16;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } pix_t;

    logic        clk;
    logic        rst;
    logic        start_orig;
    logic        start_proc;
    logic [21:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        busy;
    bit          rand_ready;

    io_frame_reader_if #(.PIX_W(8)) bus ();

    io_frame_reader #(.FRAME_PIXELS(NPIX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_orig (start_orig),
        .start_proc (start_proc),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .stream     (bus),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // image RAM: data = low address byte, one cycle after the strobe; garbage otherwise
    always @(posedge clk) begin
        rd_data <= rd_en ? rd_addr[7:0] : 8'($urandom);
    end

    // consumer ready: held high, or 50% random
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int   checks = 0;
    int   fails  = 0;
    pix_t exp_q[$];
    bit   m_busy = 1'b0;
    bit   hold_v = 1'b0;
    pix_t hold_p;
    int   m_src = 0;
    int   m_next_src = 0;
    int   m_rd_idx = 0;
    int   m_issued = 0;
    int   m_popped = 0;
    int   frame_pops = 0;
    int   bubbles = 0;
    int   frames_done = 0;
    int   first_addr = 0;
    int   first_data = 0;
    int   eof_data = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int base_of(input int s);
        return (s != 0) ? 307320 : 120;
    endfunction

    // expected frame: every address of the region, in order, markers on ends
    task automatic load_frame(input int s);
        pix_t p;
        for (int i = 0; i < NPIX; i++) begin
            p.sof  = (i == 0);
            p.eof  = (i == NPIX - 1);
            p.data = 8'(base_of(s) + i);
            exp_q.push_back(p);
        end
        m_src      = s;
        m_rd_idx   = 0;
        frame_pops = 0;
    endtask

    // per-cycle model check, sampled mid-cycle
    always @(negedge clk) begin : monitor
        pix_t got;
        pix_t p;
        int   old_src;
        int   s;
        bit   nbusy;
        got     = {bus.pix_sof, bus.pix_eof, bus.pix_data};
        old_src = m_src;
        nbusy   = m_busy;
        if (rst) begin
            chk("busy", 32'(busy), 32'(m_busy));
            if (hold_v) begin
                chk("stall_valid", 32'(bus.pix_valid), 32'd1);
                chk("stall_hold", 32'(got), 32'(hold_p));
            end
            if (m_busy && frame_pops > 0 && exp_q.size() > 0 && bus.pix_ready && !bus.pix_valid) begin
                bubbles++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                chk("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("pixel", 32'(got), 32'(p));
                    if (frame_pops == 0) first_data = 32'(got.data);
                    frame_pops++;
                    m_popped++;
                    if (p.eof) begin
                        eof_data = 32'(got.data);
                        frames_done++;
`ifdef IO_FRAME_LOOP_EN
                        load_frame(m_next_src);
`else
                        nbusy = 1'b0;
`endif
                    end
                end
            end
            if (rd_en) begin
                chk("rd_addr", 32'(rd_addr), base_of(m_src) + m_rd_idx);
                if (m_rd_idx == 0) first_addr = 32'(rd_addr);
                m_rd_idx++;
                m_issued++;
                chk("rd_per_frame", 32'(m_rd_idx <= NPIX), 32'd1);
            end
            chk("outstanding", 32'((m_issued - m_popped) <= 2), 32'd1);
            hold_v = bus.pix_valid && !bus.pix_ready;
            hold_p = got;
            if (start_orig || start_proc) begin
                s = start_orig ? 0 : 1;
                if (!m_busy) begin
                    load_frame(s);
                    m_next_src = s;
                    nbusy      = 1'b1;
                end
`ifdef IO_FRAME_LOOP_EN
                else if (s != old_src) begin
                    m_next_src = s;
                end
`endif
            end
        end else begin
            exp_q.delete();
            nbusy      = 1'b0;
            hold_v     = 1'b0;
            m_issued   = 0;
            m_popped   = 0;
            m_rd_idx   = 0;
            frame_pops = 0;
        end
        m_busy = nbusy;
    end

    task automatic pulse(input bit o, input bit p);
        @(posedge clk);
        #1;
        start_orig = o;
        start_proc = p;
        @(posedge clk);
        #1;
        start_orig = 1'b0;
        start_proc = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_frames(input int target, input int lim);
        int n;
        n = 0;
        while (frames_done < target && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frames_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    initial begin
        int n;
        bit o;
        bit p;
        rst        = 1'b0;
        start_orig = 1'b0;
        start_proc = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_sof", 32'(bus.pix_sof), 32'd0);
        chk("rst_eof", 32'(bus.pix_eof), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

`ifdef IO_FRAME_LOOP_EN
        frames_done = 0;
        pulse(1'b1, 1'b0);
        wait_frames(2, 200);
        chk("loop_busy", 32'(busy), 32'd1);
        pulse(1'b0, 1'b1);
        wait_frames(4, 200);
        chk("loop_switched_base", first_addr, 307320);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("loop_reset_busy", 32'(busy), 32'd0);
        chk("loop_reset_valid", 32'(bus.pix_valid), 32'd0);
`else
        // 1: original image, ready held high
        bubbles = 0;
        pulse(1'b1, 1'b0);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        chk("t1_valid_c1", 32'(bus.pix_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_c2", 32'(bus.pix_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_c3", 32'(bus.pix_valid), 32'd1);
        chk("t1_first_data", 32'(bus.pix_data), 32'h78);
        chk("t1_first_sof", 32'(bus.pix_sof), 32'd1);
        wait_idle(100);
        chk("t1_first_addr", first_addr, 120);
        chk("t1_eof_data", eof_data, 32'h87);
        chk("t1_bubbles", bubbles, 0);

        // 2: processed image
        pulse(1'b0, 1'b1);
        wait_idle(100);
        chk("t2_first_addr", first_addr, 307320);
        chk("t2_first_data", first_data, 32'h78);
        chk("t2_eof_data", eof_data, 32'h87);
        chk("t2_bubbles", bubbles, 0);

        // 4: simultaneous starts pick original; mid-frame start ignored
        pulse(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        pulse(1'b0, 1'b1);
        wait_idle(100);
        chk("t4_first_addr", first_addr, 120);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_queued_start", 32'(busy), 32'd0);

        // 3: random back-pressure, random sources and stray starts
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            o = 1'($urandom_range(0, 1));
            p = o ? 1'($urandom_range(0, 1)) : 1'b1;
            pulse(o, p);
            repeat ($urandom_range(1, 10)) @(posedge clk);
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(400);
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        // 5: reset mid-frame, then a clean restart
        pulse(1'b1, 1'b0);
        n = 0;
        while (frame_pops < 7 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_pixel7", 32'(frame_pops >= 7), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_valid_after_rst", 32'(bus.pix_valid), 32'd0);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        rst = 1'b1;
        pulse(1'b0, 1'b1);
        wait_idle(100);
        chk("t5_first_addr", first_addr, 307320);
        chk("t5_first_data", first_data, 32'h78);
        chk("t5_eof_data", eof_data, 32'h87);
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
